// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N byte producers
//
// Ports:
//   clk, nRst       clock, asynchronous active-low reset
//   req[N]          per-requester byte ready (level, held until ack)
//   data[8N]        requester i byte on data[8i+7:8i]
//   lock[N]         only with UART_ARB_LOCK_EN: hold ownership for a multi-byte frame
//   ack[N]          one-hot 1-cycle pulse, byte accepted
//   grant[N]        one-hot owner of the byte in flight, 0 when idle
//   uart_transmit   1-cycle start pulse to the UART
//   uart_data[8]    byte to the UART, held until the next grant
//   uart_busy_tx    UART busy flag
//   err             sticky handshake timeout (busy_tx never rose)
//
// Optional feature macro: UART_ARB_LOCK_EN
module uart_tx_arbiter #(
  parameter int N      = 4,
  parameter int TO_CYC = 4
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           uart_transmit,
  output logic [7:0]     uart_data,
  input  logic           uart_busy_tx,
  output logic           err
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TO_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d, ack_q, ack_d;
  logic          tx_q, tx_d, err_q, err_d;
  logic [7:0]    data_q, data_d;
  logic          found;
  logic [PW-1:0] win, ptr_inc;
  logic [PW:0]   idx;
  logic [N-1:0]  win_oh;
`ifdef UART_ARB_LOCK_EN
  logic [4:0]    lcnt_q, lcnt_d;
  logic [PW-1:0] own;
  logic          others;
`endif
  // First set req at or above the pointer, wrapping N-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (PW+1)'(ptr_q) + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end
  // Explicit mod so non-power-of-2 N wraps correctly.
  assign ptr_inc = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win;
`ifdef UART_ARB_LOCK_EN
  always_comb begin
    own = '0;
    for (int k = 0; k < N; k++) if (grant_q[k]) own = PW'(k);
  end
  assign others = |(req & ~grant_q);
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    tx_d    = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
`ifdef UART_ARB_LOCK_EN
    lcnt_d  = lcnt_q;
`endif
    case (state_q)
      IDLE: if (found && !uart_busy_tx) begin
        grant_d = win_oh;
        ack_d   = win_oh;
        data_d  = data[{win, 3'b000} +: 8];
        tx_d    = 1'b1;
        ptr_d   = ptr_inc;
        state_d = ISSUE;
`ifdef UART_ARB_LOCK_EN
        lcnt_d  = 5'd1;
`endif
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (uart_busy_tx) state_d = WAIT_LO;
      else begin
        cnt_d = cnt_q + 1'b1;
        // Busy never rose: the byte is dropped, not retried.
        if (cnt_d == CW'(TO_CYC)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      WAIT_LO: if (!uart_busy_tx) begin
        grant_d = '0;
        state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
        // Locked owner keeps the UART; after 16 bytes it yields if anyone else waits.
        if (lock[own] && req[own] && (lcnt_q < 5'd16 || !others)) begin
          grant_d = grant_q;
          ack_d   = grant_q;
          data_d  = data[{own, 3'b000} +: 8];
          tx_d    = 1'b1;
          state_d = ISSUE;
          lcnt_d  = lcnt_q + {4'd0, lcnt_q != 5'd16};
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      tx_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
      lcnt_q  <= lcnt_d;
`endif
    end
  end
  assign ack           = ack_q;
  assign grant         = grant_q;
  assign uart_transmit = tx_q;
  assign uart_data     = data_q;
  assign err           = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO_CYC = 4;
  logic clk = 1'b0, nRst = 1'b0, busy = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0] ack, grant;
  logic tx, err;
  logic [7:0] udata;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N(N), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .nRst(nRst), .req(req), .data(data),
`ifdef UART_ARB_LOCK_EN
    .lock('0),
`endif
    .ack(ack), .grant(grant), .uart_transmit(tx), .uart_data(udata),
    .uart_busy_tx(busy), .err(err)
  );
  int checks = 0, errors = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // reference model: byte in flight, its age in cycles since acceptance, whether busy was seen
  int m_ptr = 0, m_age = 0;
  bit m_fly = 0, m_hi = 0, m_err = 0;
  logic [7:0] m_byte = '0;
  logic [N-1:0] e_ack = '0, e_grant = '0;
  logic e_tx = 1'b0;
  // UART stand-in and requester behaviour
  int pre = 0, hi = 0, stub_mode = 0, req_mode = 0;
  int ack_log[$];
  logic [7:0] byte_log[$];
  task automatic model_edge();
    int w;
    e_ack = '0;
    e_tx = 1'b0;
    if (!nRst) begin
      m_ptr = 0; m_fly = 0; m_hi = 0; m_err = 0; m_byte = '0; e_grant = '0;
      return;
    end
    if (!m_fly) begin
      e_grant = '0;
      if (req != 0 && !busy) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_byte = data[8*w +: 8];
        e_ack[w] = 1'b1;
        e_grant[w] = 1'b1;
        e_tx = 1'b1;
        m_ptr = (w + 1) % N;
        m_fly = 1; m_age = 0; m_hi = 0;
      end
    end else begin
      m_age++;
      if (m_age > 1) begin
        if (m_hi) begin
          if (!busy) begin m_fly = 0; e_grant = '0; end
        end else if (busy) m_hi = 1;
        else if (m_age - 1 == TO_CYC) begin m_err = 1; m_fly = 0; e_grant = '0; end
      end
    end
  endtask
  task automatic drive();
    if (!nRst) begin pre = 0; hi = 0; end
    else if (stub_mode != 3) begin
      if (tx) begin
        if (stub_mode == 2 || (stub_mode == 1 && $urandom_range(0, 7) == 0)) begin pre = 0; hi = 0; end
        else begin pre = $urandom_range(0, 2); hi = $urandom_range(1, 6); end
      end else if (stub_mode == 1 && pre == 0 && hi == 0 && $urandom_range(0, 15) == 0) hi = $urandom_range(1, 3);
    end
    if (stub_mode != 3) begin
      if (pre > 0) begin pre--; busy = 1'b0; end
      else if (hi > 0) begin hi--; busy = 1'b1; end
      else busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if (req_mode == 1) req[i] = 1'b0;
        else if (req_mode == 2) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          else data[8*i +: 8] = 8'($urandom);
        end
      end else if (req_mode == 2 && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask
  task automatic tick();
    drive();
    model_edge();
    @(negedge clk);
    check("ack", 32'(ack), 32'(e_ack));
    check("grant", 32'(grant), 32'(e_grant));
    check("transmit", 32'(tx), 32'(e_tx));
    check("err", 32'(err), 32'(m_err));
    check("uart_data", 32'(udata), 32'(m_byte));
    for (int i = 0; i < N; i++) if (ack[i]) begin ack_log.push_back(i); byte_log.push_back(udata); end
  endtask
  task automatic run_until(int n, int lim);
    int base, c;
    base = ack_log.size();
    c = 0;
    while (ack_log.size() < base + n && c < lim) begin tick(); c++; end
    check("acks_seen", 32'(ack_log.size()), 32'(base + n));
  endtask
  task automatic wait_idle(int lim);
    int c;
    c = 0;
    while (grant != 0 && c < lim) begin tick(); c++; end
    check("idle", 32'(grant), 32'd0);
  endtask
  task automatic do_reset();
    nRst = 1'b0;
    tick();
    tick();
    check("rst_outputs", {grant, ack, tx, err, udata}, 32'd0);
    nRst = 1'b1;
    ack_log.delete();
    byte_log.delete();
  endtask
  initial begin
    int exp2[6], exp3[4], n0, c;
    logic [7:0] eb2[6];
    exp2 = '{0, 1, 2, 3, 0, 1};
    eb2 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21};
    exp3 = '{2, 3, 0, 1};
    do_reset();
    // single requester
    req_mode = 1; stub_mode = 0;
    data[7:0] = 8'hA5; req = 4'b0001;
    run_until(1, 50);
    repeat (20) tick();
    check("single_once", 32'(ack_log.size()), 32'd1);
    check("single_byte", 32'(byte_log[0]), 32'hA5);
    check("single_grant_end", 32'(grant), 32'd0);
    // all four held: round-robin order
    do_reset();
    req_mode = 0;
    data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    run_until(6, 300);
    req = '0;
    for (int i = 0; i < 6; i++) begin
      check("rr_order", 32'(ack_log[i]), 32'(exp2[i]));
      check("rr_byte", 32'(byte_log[i]), 32'(eb2[i]));
    end
    wait_idle(30);
    // pointer wrap 3 -> 0
    do_reset();
    req_mode = 1;
    req = 4'b0100;
    run_until(1, 50);
    wait_idle(30);
    req = 4'b1001;
    run_until(2, 100);
    req = 4'b0011;
    run_until(1, 100);
    for (int i = 0; i < 4; i++) check("wrap_order", 32'(ack_log[i]), 32'(exp3[i]));
    wait_idle(30);
    req = '0;
    repeat (20) tick();
    // handshake timeout, then service continues
    stub_mode = 2;
    req = 4'b0010;
    run_until(1, 50);
    repeat (8) tick();
    check("to_err", 32'(err), 32'd1);
    check("to_grant", 32'(grant), 32'd0);
    stub_mode = 0;
    req = 4'b0001;
    run_until(1, 50);
    check("to_next", 32'(ack_log[ack_log.size() - 1]), 32'd0);
    wait_idle(30);
    // busy held in IDLE blocks arbitration
    stub_mode = 3; busy = 1'b1;
    n0 = ack_log.size();
    req = 4'b0100;
    repeat (6) tick();
    check("busy_noack", 32'(ack_log.size()), 32'(n0));
    busy = 1'b0;
    tick();
    check("busy_grant", 32'(grant), 32'b0100);
    stub_mode = 0;
    wait_idle(30);
    // reset in the middle of a byte
    req = 4'b0100;
    c = 0;
    while (!(grant != 0 && busy) && c < 30) begin tick(); c++; end
    check("mid_reach", 32'(grant != 0 && busy), 32'd1);
    tick();
    nRst = 1'b0;
    tick();
    check("mid_rst", {grant, ack, tx, err}, 32'd0);
    nRst = 1'b1;
    ack_log.delete();
    req_mode = 0;
    req = 4'b1111;
    run_until(1, 20);
    check("mid_first", 32'(ack_log[0]), 32'd0);
    // randomized traffic, timeouts, spurious busy and occasional resets
    req = '0;
    req_mode = 2; stub_mode = 1;
    repeat (3000) begin
      nRst = ($urandom_range(0, 999) != 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter among N byte-producing requesters.
It accepts one byte at a time from the winning requester and drives the UART transmit/data_tx inputs.
It holds off further grants until the UART's busy_tx has risen and fallen again.
It sits between on-chip byte sources (debug, status, response paths) and the uart block's TX side.

Parameters:
N, 4, number of requesters (2..8)
TO_CYC, 4, cycles allowed in WAIT_HI for busy_tx to rise before a handshake error is flagged

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
req  input  N  per-requester byte-ready; level, held until ack
data  input  8*N  requester i byte on data[8i+7:8i]
ack  output  N  one-hot, 1-cycle pulse: requester's byte accepted, may present next byte
grant  output  N  one-hot owner of the UART for the byte in flight; 0 when idle
uart_transmit  output  1  to uart transmit; 1-cycle pulse
uart_data  output  8  to uart data_tx; stable from ISSUE until return to IDLE
uart_busy_tx  input  1  from uart busy_tx
err  output  1  sticky handshake timeout flag

Behaviour:
- Reset is asynchronous on nRst low, clock is clk.
- Reset values: uart_transmit=0, uart_data=0, ack=0, grant=0, err=0, state=IDLE, rr pointer=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE:
  - Arbitrates only when at least one req bit is set and uart_busy_tx==0.
  - Winner is the first set req bit searching upward from the pointer, wrapping N-1 to 0.
  - Same edge: grant<=onehot(winner), ack<=onehot(winner) for 1 cycle, uart_data<=data slice of winner, uart_transmit<=1, pointer<=(winner+1) mod N, go to ISSUE.
  - If uart_busy_tx==1 in IDLE (UART still finishing), stay in IDLE and do not grant.
- ISSUE:
  - uart_transmit<=0, ack<=0, timeout counter<=0, go to WAIT_HI.
  - uart_transmit is high for exactly one cycle per byte.
- WAIT_HI:
  - If uart_busy_tx==1, go to WAIT_LO.
  - Else increment the counter. When it reaches TO_CYC: err<=1, grant<=0, go to IDLE. The byte is considered lost and is not retried.
- WAIT_LO: when uart_busy_tx==0, grant<=0 and go to IDLE. The next grant is possible on the following edge.
- Accepted byte and requester behaviour:
  - Byte is captured at grant time; requester data may change after ack.
  - A requester deasserting req after ack does not affect the byte in flight.
  - A requester that keeps req high gets another turn only after the other active requesters have been served (fairness).
- Pointer is a log2(N)-bit register. Wrap-around N-1 -> 0 is required. Non-power-of-2 N uses an explicit mod.
- Simultaneous requests: exactly one ack per byte, never two in one cycle. ack is never asserted outside the IDLE->ISSUE edge.
- err is cleared only by reset; arbitration continues normally after err.
- Reset mid-byte: all outputs return to reset values immediately. The UART is reset by the same nRst.
- Minimum cycles per byte = 10*(BAUD+1) UART time + 3 arbiter cycles.

Optional Feature:
Macro: UART_ARB_LOCK_EN.
- Defined:
  - Adds input lock [N], held by a requester to send a multi-byte frame atomically.
  - In WAIT_LO completion, if lock[owner]==1 and req[owner]==1, the owner is re-granted directly. grant stays set and the pointer is not advanced.
  - The lock is broken after 16 consecutive bytes if any other req is set, to bound starvation.
- Not defined: no lock port. Every byte is arbitrated round-robin independently.

Test Plan:
- Single requester: req=4'b0001, data[7:0]=8'hA5, UART BAUD reduced to 9'd7 -> ack[0] pulse once; uart_transmit 1 cycle; tx line shows start, 1,0,1,0,0,1,0,1, stop; grant returns to 0 after busy_tx falls.
- All four req high with data 8'h10/8'h21/8'h32/8'h43 and held -> ack order 0,1,2,3,0,1; the byte sequence on tx matches that order.
- Pointer wrap: pointer at 3, req=4'b1001 -> requester 3 granted, then requester 0; pointer ends at 1.
- Timeout: uart_busy_tx tied 0 after issue, req=4'b0010 -> err rises 4 cycles after WAIT_HI entry, grant clears, and the next req is still served.
- busy_tx held 1 in IDLE with req=4'b0100 -> no ack and no uart_transmit until busy_tx falls, then grant within 1 cycle.
- nRst pulsed low during WAIT_LO -> grant=0, uart_transmit=0, err=0, pointer=0; requester 0 is served first after release.
